instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Front end of the multicycle CPU, directly upstream of the control unit.
- Owns the PC and the instruction register (IR).
- Runs the instruction-memory read handshake on a fetch request and decodes the IR fields that the control unit and datapath consume.
- Applies PC updates selected by the control unit's pc_src when PC write is enabled.

Parameters:
- WORD_W, 16, datapath, PC and instruction width.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_start  in  1  control-unit pulse (IF_1) requesting a fetch at the current PC.
- pc_write  in  1  PC write enable (control unit's PVSWriteEn).
- pc_src  in  2  0: PC+1; 1: alu_out; 2: jump target; 3: hold.
- alu_out  in  WORD_W  ALU result (branch/JPR/JRL target).
- mem_read  out  1  instruction-memory read request.
- mem_addr  out  WORD_W  fetch address.
- mem_data  in  WORD_W  instruction word returned by memory.
- mem_ack  in  1  memory has valid data on mem_data this cycle.
- fetch_busy  out  1  high in REQ or DONE.
- inst_valid  out  1  one-cycle pulse: IR updated this cycle.
- pc  out  WORD_W  current PC.
- pc_plus1  out  WORD_W  pc+1, combinational.
- opcode  out  4  IR[15:12].
- rs  out  2  IR[11:10].
- rt  out  2  IR[9:8].
- rd  out  2  IR[7:6].
- func_code  out  6  IR[5:0].
- imm_sext  out  WORD_W  sign-extended IR[7:0].
- jmp_target  out  WORD_W  {pc[15:12], IR[11:0]}.
- num_inst  out  WORD_W  count of completed fetches.

Behaviour:
- Reset values: pc=RESET_PC; IR=0; state=IDLE; mem_read=0; mem_addr=0; inst_valid=0; fetch_busy=0; num_inst=0.
- IDLE:
  - fetch_start=1 -> latch fetch_addr<=pc, go REQ.
  - fetch_start=0 -> stay in IDLE.
- REQ:
  - mem_read=1 and mem_addr=fetch_addr, held stable every cycle until the ack.
  - mem_ack=1 -> IR<=mem_data, go DONE.
  - The ack may arrive in the first REQ cycle, giving minimum latency: fetch_start edge -> inst_valid two cycles later.
- DONE:
  - inst_valid=1 for exactly one cycle; num_inst<=num_inst+1 (wraps at 2^WORD_W).
  - mem_read=0; go IDLE.
- mem_ack outside REQ is ignored; IR is unchanged.
- fetch_start while in REQ/DONE is ignored (no queuing).
- Decoded fields come from the IR register, so they are stable from the inst_valid cycle until the next DONE.
- PC update, independent of the FSM, when pc_write=1 at the clock edge:
  - pc_src=0 -> pc+1 (16-bit wrap; 16'hFFFF -> 16'h0000).
  - pc_src=1 -> alu_out.
  - pc_src=2 -> jmp_target, computed from the pre-update pc.
  - pc_src=3 -> unchanged.
- pc_write during REQ changes pc but not the in-flight fetch_addr.
- fetch_start and pc_write in the same IDLE cycle: the fetch uses the old pc; pc updates.
- Reset mid-fetch (REQ or DONE): return to IDLE next edge with mem_read=0; any inst_valid pulse is suppressed; IR clears.

Decomposition:
- Shared package / opcodes include file:
  - pc_src encodings (PCSRC_PC1, PCSRC_ALU, PCSRC_JMP, PCSRC_HOLD).
  - Fetch state encodings (FS_IDLE, FS_REQ, FS_DONE).
  - IR field bit positions.
  - WORD_W.
- One natural sub-module, inst_field_decode: combinational IR -> opcode, rs, rt, rd, func_code, imm_sext and jmp_target (with the pc input).
- FSM, PC register and counter stay in the top.

Test Plan:
- Reset, then fetch_start with mem_ack asserted one cycle after mem_read, mem_data=16'hF01C -> mem_addr=0; inst_valid pulses once; opcode=4'hF, func_code=6'h1C, rs=0, rt=0, rd=0; num_inst=1.
- Memory stalls 5 cycles before mem_ack -> mem_read and mem_addr held for all 5+1 REQ cycles; no inst_valid until the ack; mem_data=16'h4A85 gives imm_sext=16'hFF85.
- pc=16'h3005 with IR=16'h9123, pc_write=1: pc_src=2 -> pc=16'h3123; pc_src=1 with alu_out=16'h0040 -> pc=16'h0040; pc=16'hFFFF, pc_src=0 -> pc=16'h0000; pc_src=3 -> unchanged.
- fetch_start and pc_write (pc_src=0) in the same cycle at pc=16'h0010 -> mem_addr=16'h0010, pc becomes 16'h0011; a second fetch_start during REQ is ignored (single inst_valid).
- Reset asserted in the REQ cycle with mem_ack high -> no IR update, no inst_valid; mem_read=0 next cycle; pc=RESET_PC; num_inst=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch front end: PC-source selects,
// fetch FSM states and the instruction-word field layout.
package instr_fetch_unit_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    PCSRC_PC1  = 2'd0,
    PCSRC_ALU  = 2'd1,
    PCSRC_JMP  = 2'd2,
    PCSRC_HOLD = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

  // Instruction word field boundaries (inclusive bit positions)
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int RS_HI     = 11;
  localparam int RS_LO     = 10;
  localparam int RT_HI     = 9;
  localparam int RT_LO     = 8;
  localparam int RD_HI     = 7;
  localparam int RD_LO     = 6;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;
  localparam int JMP_HI    = 11;
  localparam int JMP_LO    = 0;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational split of the instruction register into the fields consumed
// by the control unit and datapath.
module inst_field_decode
  import instr_fetch_unit_pkg::*;
#(
  parameter int WIDTH = instr_fetch_unit_pkg::WORD_W
) (
  input  logic [WIDTH-1:0]      ir,
  input  logic [WIDTH-1:JMP_HI+1] pc_region,
  output logic [3:0]            opcode,
  output logic [1:0]            rs,
  output logic [1:0]            rt,
  output logic [1:0]            rd,
  output logic [5:0]            func_code,
  output logic [WIDTH-1:0]      imm_sext,
  output logic [WIDTH-1:0]      jmp_target
);

  assign opcode    = ir[OPCODE_HI:OPCODE_LO];
  assign rs        = ir[RS_HI:RS_LO];
  assign rt        = ir[RT_HI:RT_LO];
  assign rd        = ir[RD_HI:RD_LO];
  assign func_code = ir[FUNC_HI:FUNC_LO];

  assign imm_sext   = {{(WIDTH-IMM_HI-1){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
  // Jumps stay inside the current PC region; only the low bits come from IR
  assign jmp_target = {pc_region, ir[JMP_HI:JMP_LO]};

endmodule

// File: rtl/instr_fetch_unit.sv
// Front end of the multicycle CPU: owns PC and IR, runs the instruction-memory
// read handshake and exposes the decoded instruction fields.
module instr_fetch_unit #(
  parameter int                           WORD_W   = instr_fetch_unit_pkg::WORD_W,
  parameter logic [WORD_W-1:0]            RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_write,
  input  logic [1:0]        pc_src,
  input  logic [WORD_W-1:0] alu_out,
  output logic              mem_read,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              fetch_busy,
  output logic              inst_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus1,
  output logic [3:0]        opcode,
  output logic [1:0]        rs,
  output logic [1:0]        rt,
  output logic [1:0]        rd,
  output logic [5:0]        func_code,
  output logic [WORD_W-1:0] imm_sext,
  output logic [WORD_W-1:0] jmp_target,
  output logic [WORD_W-1:0] num_inst
);

  import instr_fetch_unit_pkg::*;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] fetch_addr;
  logic [WORD_W-1:0] pc_next;

  inst_field_decode #(.WIDTH(WORD_W)) u_decode (
    .ir         (ir),
    .pc_region  (pc[WORD_W-1:JMP_HI+1]),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .func_code  (func_code),
    .imm_sext   (imm_sext),
    .jmp_target (jmp_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    inst_valid = 1'b0;
    fetch_busy = 1'b0;
    case (state)
      FS_IDLE: begin
        if (fetch_start) state_next = FS_REQ;
      end
      FS_REQ: begin
        mem_read   = 1'b1;
        fetch_busy = 1'b1;
        if (mem_ack) state_next = FS_DONE;
      end
      FS_DONE: begin
        inst_valid = 1'b1;
        fetch_busy = 1'b1;
        state_next = FS_IDLE;
      end
      default: state_next = FS_IDLE;
    endcase
  end

  assign mem_addr = fetch_addr;
  assign pc_plus1 = pc + WORD_W'(1);

  // Jump target is formed from the current (pre-update) PC
  always_comb begin
    pc_next = pc;
    case (pc_src_t'(pc_src))
      PCSRC_PC1:  pc_next = pc_plus1;
      PCSRC_ALU:  pc_next = alu_out;
      PCSRC_JMP:  pc_next = jmp_target;
      PCSRC_HOLD: pc_next = pc;
      default:    pc_next = pc;
    endcase
  end

  // The fetch address is captured once so later PC writes cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr <= '0;
      ir         <= '0;
      num_inst   <= '0;
      pc         <= RESET_PC;
    end else begin
      if (state == FS_IDLE && fetch_start) fetch_addr <= pc;
      if (state == FS_REQ && mem_ack)      ir <= mem_data;
      if (state == FS_DONE)                num_inst <= num_inst + WORD_W'(1);
      if (pc_write)                        pc <= pc_next;
    end
  end

endmodule
